// File: rtl/fsqrt_arbiter.sv
// fsqrt_arbiter: round-robin, credit-checked sharing of one fixed-latency fsqrt pipe (req_valid/req_x/req_ready in, sq_x/sq_y to the pipe, resp_valid/resp_id/resp_y/resp_ready out, busy)
module fsqrt_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]    req_ready,
  output logic [31:0]         sq_x,
  input  logic [31:0]         sq_y,
  output logic                resp_valid,
  output logic [IDW-1:0]      resp_id,
  output logic [31:0]         resp_y,
  input  logic                resp_ready,
  output logic                busy
);
  localparam int IW = $clog2(LAT + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [IDW-1:0] rr_ptr, grant;
  logic           any, credit_ok, issue, push, pop;
  logic [LAT:1]   tv;
  logic [IDW-1:0] tid [1:LAT];
  logic [IW-1:0]  icnt;
  logic [FW-1:0]  fcnt;
  logic [PW-1:0]  rp, wp;
  logic [IDW-1:0] fid [DEPTH];
  logic [31:0]    fy  [DEPTH];
  always_comb begin
    any   = 1'b0;
    grant = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        any   = 1'b1;
        grant = IDW'((int'(rr_ptr) + k) % N_REQ);
      end
  end
  assign credit_ok  = (int'(icnt) + int'(fcnt)) < DEPTH;
  assign issue      = any & credit_ok & ~rst;
  assign req_ready  = issue ? N_REQ'(1) << grant : '0;
  assign sq_x       = issue ? req_x[int'(grant)*32 +: 32] : '0;
  assign push       = tv[LAT];
  assign resp_valid = fcnt != '0;
  assign pop        = resp_valid & resp_ready;
  assign resp_id    = fid[rp];
  assign resp_y     = fy[rp];
  assign busy       = (icnt != '0) | resp_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      tv     <= '0;
      icnt   <= '0;
      fcnt   <= '0;
      rp     <= '0;
      wp     <= '0;
    end else begin
      if (issue) rr_ptr <= int'(grant) == N_REQ - 1 ? '0 : grant + IDW'(1);
      for (int k = LAT; k > 1; k--) begin
        tv[k]  <= tv[k-1];
        tid[k] <= tid[k-1];
      end
      tv[1]  <= issue;
      tid[1] <= grant;
      icnt   <= icnt + IW'(issue) - IW'(tv[LAT]);
      fcnt   <= fcnt + FW'(push) - FW'(pop);
      if (push) begin
        fid[wp] <= tid[LAT];
        fy[wp]  <= sq_y;
        wp      <= int'(wp) == DEPTH - 1 ? '0 : wp + PW'(1);
      end
      if (pop) rp <= int'(rp) == DEPTH - 1 ? '0 : rp + PW'(1);
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(push && int'(fcnt) == DEPTH && !pop));
endmodule

// File: tb/tb_fsqrt_arbiter.sv
// tb_fsqrt_arbiter: directed vectors plus randomized traffic against a queue-based reference model
module tb_fsqrt_arbiter;
  localparam int N = 4, LAT = 2, DEPTH = 4, IDW = 2;
  logic           clk = 1'b0, rst = 1'b1, resp_ready = 1'b1;
  logic [N-1:0]   req_valid = '0, req_ready;
  logic [32*N-1:0] req_x = '0;
  logic [31:0]    sq_x, sq_y, resp_y;
  logic           resp_valid, busy;
  logic [IDW-1:0] resp_id;
  logic [31:0]    pipe [LAT];
  typedef struct {int id; logic [31:0] y; int rdy;} resp_t;
  typedef struct {int id; logic [31:0] x; logic [31:0] y;} vec_t;
  resp_t q[$];
  int optr = 0, outst = 0, cyc = 0, checks = 0, errors = 0;
  logic [N-1:0] s_ready;
  logic s_rv, s_busy;
  logic [IDW-1:0] s_id;
  logic [31:0] s_y;
  fsqrt_arbiter #(.N_REQ(N), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .sq_x(sq_x), .sq_y(sq_y), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_y(resp_y), .resp_ready(resp_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fsq(input logic [31:0] x);
    case (x)
      32'h40800000: fsq = 32'h40000000;
      32'h3F800000: fsq = 32'h3F800000;
      32'h41100000: fsq = 32'h40400000;
      32'h41800000: fsq = 32'h40800000;
      32'h00000000: fsq = 32'h00000000;
      32'h80000000: fsq = 32'h80000000;
      default:      fsq = {1'b0, x[31:1] ^ 31'h2A5A5A5A};
    endcase
  endfunction
  always_ff @(posedge clk) begin
    pipe[0] <= fsq(sq_x);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign sq_y = pipe[LAT-1];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic step();
    bit erv, iss;
    int g;
    logic [N-1:0] er;
    logic [31:0] ex;
    #1;
    s_ready = req_ready; s_rv = resp_valid; s_busy = busy; s_id = resp_id; s_y = resp_y;
    erv = q.size() > 0 && q[0].rdy <= cyc;
    g = -1;
    for (int k = 0; k < N && g < 0; k++) if (req_valid[(optr + k) % N]) g = (optr + k) % N;
    iss = !rst && g >= 0 && outst < DEPTH;
    er = '0;
    ex = '0;
    if (iss) begin
      er = 4'(1) << g;
      ex = req_x[32*g +: 32];
    end
    chk("model_req_ready", s_ready, er);
    chk("model_sq_x", sq_x, ex);
    chk("model_resp_valid", s_rv, erv);
    chk("model_busy", s_busy, outst > 0);
    if (erv) begin
      chk("model_resp_id", s_id, q[0].id);
      chk("model_resp_y", s_y, q[0].y);
    end
    if (erv && resp_ready) begin
      void'(q.pop_front());
      outst--;
    end
    if (iss) begin
      q.push_back('{g, fsq(ex), cyc + LAT + 1});
      outst++;
      optr = (g + 1) % N;
    end
    if (rst) begin
      q.delete();
      outst = 0;
      optr = 0;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic drain();
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (8) step();
  endtask
  initial begin
    vec_t vt[6];
    logic [31:0] ys[4];
    int n;
    vt[0] = '{0, 32'h40800000, 32'h40000000};
    vt[1] = '{1, 32'h3F800000, 32'h3F800000};
    vt[2] = '{2, 32'h41100000, 32'h40400000};
    vt[3] = '{3, 32'h41800000, 32'h40800000};
    vt[4] = '{0, 32'h80000000, 32'h80000000};
    vt[5] = '{3, 32'h00000000, 32'h00000000};
    ys = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h00000000};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_reset();
    foreach (vt[i]) begin
      do_reset();
      req_x = '0;
      req_x[32*vt[i].id +: 32] = vt[i].x;
      req_valid = 4'(1) << vt[i].id;
      for (int c = 0; c <= 4; c++) begin
        step();
        if (c == 0) chk("single_grant", s_ready, 4'(1) << vt[i].id);
        req_valid = '0;
        if (c >= 1 && c <= 3) chk("single_busy", s_busy, 1);
        if (c == 3) begin
          chk("single_resp_valid", s_rv, 1);
          chk("single_resp_id", s_id, vt[i].id);
          chk("single_resp_y", s_y, vt[i].y);
        end
        if (c == 4) chk("single_idle", s_busy, 0);
      end
    end
    do_reset();
    req_x = {32'h00000000, 32'h41800000, 32'h41100000, 32'h3F800000};
    req_valid = '1;
    for (int c = 0; c <= 6; c++) begin
      step();
      if (c < 4) chk("all4_grant", s_ready, 4'(1) << c);
      if (c >= 3) begin
        chk("all4_resp_id", s_id, c - 3);
        chk("all4_resp_y", s_y, ys[c-3]);
      end
      req_valid &= ~s_ready;
    end
    drain();
    do_reset();
    resp_ready = 1'b0;
    req_valid = '1;
    n = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 10) resp_ready = 1'b1;
      step();
      n += $countones(s_ready);
      if (c == 3) chk("bp_issue_count", n, 4);
      if (c >= 4 && c <= 10) chk("bp_stalled", s_ready, 0);
      if (c == 9) chk("bp_full_valid", s_rv, 1);
      if (c == 11) chk("bp_resume", s_ready != 0, 1);
      if (c >= 10) begin
        chk("bp_pop_valid", s_rv, 1);
        chk("bp_pop_id", s_id, (c - 10) % 4);
      end
    end
    drain();
    do_reset();
    req_valid = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("fair_grant", s_ready, c % 2 ? 4'b0100 : 4'b0001);
    end
    drain();
    do_reset();
    req_valid = 4'b0011;
    step();
    chk("rst_first_grant", s_ready, 4'b0001);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0100;
    rst = 1'b1;
    step();
    chk("rst_no_issue", s_ready, 0);
    rst = 1'b0;
    req_valid = '0;
    for (int c = 3; c <= 10; c++) begin
      step();
      chk("rst_resp_valid", s_rv, 0);
      chk("rst_busy", s_busy, 0);
    end
    req_valid = '1;
    step();
    chk("rst_ptr_zero", s_ready, 4'b0001);
    drain();
    req_valid = '0;
    for (int c = 0; c < 800; c++) begin
      resp_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 199) == 0;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_x[32*i +: 32] = $urandom;
        end
      step();
      req_valid &= ~s_ready;
    end
    rst = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
